iq_lo_ctrl: RTL

//  Sequencer for the IQ demodulator quadrature local oscillator (LO).
//  - Generates the 4-phase cos/sin codes {+1,0,-1,0} with a programmable quarter-phase hold.
//  - Start/stop/sync control; counts LO periods and ends a run after a programmed length.
//  - Sits between the demod control registers and the I/Q mixers.
//  - Drives cos/sin plus a phase strobe used by the downstream accumulators.

---
 rtl/iq_lo_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/iq_lo_ctrl.sv
// Quadrature LO sequencer: steps cos/sin through four quarter phases with a
// programmable hold, counts LO periods and ends a run on length, stop or reset.
module iq_lo_ctrl #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic              start,
    input  logic              stop,
    input  logic              sync,
    output logic signed [1:0] cosine_out,
    output logic signed [1:0] sine_out,
    output logic              phase_strobe,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  period_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t            state, state_nx;
    logic [1:0]        q, q_nx;
    logic [DIV_W-1:0]  hold, hold_nx;
    logic [DIV_W-1:0]  div_l, div_nx;
    logic [CNT_W-1:0]  len_l, len_nx;
    logic [CNT_W-1:0]  cnt_nx, cnt_inc;
    logic              strobe_nx;
    logic              last_hold, len_end;
    logic signed [1:0] cos_nx, sin_nx;

    assign cnt_inc   = period_cnt + CNT_W'(1);
    assign last_hold = (hold == div_l - DIV_W'(1));
    // Natural end only on the 3->0 wrap that reaches the programmed length.
    assign len_end   = last_hold && (q == 2'd3) && (len_l != '0) && (cnt_inc == len_l);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        q_nx      = q;
        hold_nx   = hold;
        div_nx    = div_l;
        len_nx    = len_l;
        cnt_nx    = period_cnt;
        strobe_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    div_nx   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                    len_nx   = cfg_len;
                    cnt_nx   = '0;
                    hold_nx  = '0;
                    q_nx     = 2'd0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = FINISH;
                    q_nx     = 2'd0;
                    hold_nx  = '0;
                end else if (len_end) begin
                    state_nx = FINISH;
                    q_nx     = 2'd0;
                    hold_nx  = '0;
                    cnt_nx   = cnt_inc;
                end else if (sync) begin
                    hold_nx   = '0;
                    q_nx      = 2'd0;
                    strobe_nx = (q != 2'd0);
                end else if (last_hold) begin
                    hold_nx   = '0;
                    q_nx      = q + 2'd1;
                    strobe_nx = 1'b1;
                    if (q == 2'd3) cnt_nx = cnt_inc;
                end else begin
                    hold_nx = hold + DIV_W'(1);
                end
            end
            FINISH: begin
                state_nx = IDLE;
                q_nx     = 2'd0;
                hold_nx  = '0;
            end
            default: begin
                state_nx = IDLE;
                q_nx     = 2'd0;
                hold_nx  = '0;
            end
        endcase
    end

    // Outputs are registered, so decode from the next phase rather than the current one.
    always_comb begin
        cos_nx = 2'sb00;
        sin_nx = 2'sb00;
        case (q_nx)
            2'd0:    cos_nx = 2'sb01;
            2'd1:    sin_nx = 2'sb01;
            2'd2:    cos_nx = 2'sb11;
            default: sin_nx = 2'sb11;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            q            <= 2'd0;
            hold         <= '0;
            div_l        <= DIV_W'(1);
            len_l        <= '0;
            cosine_out   <= 2'sb01;
            sine_out     <= 2'sb00;
            phase_strobe <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            period_cnt   <= '0;
        end else begin
            state        <= state_nx;
            q            <= q_nx;
            hold         <= hold_nx;
            div_l        <= div_nx;
            len_l        <= len_nx;
            cosine_out   <= cos_nx;
            sine_out     <= sin_nx;
            phase_strobe <= strobe_nx;
            busy         <= (state_nx == RUN);
            done         <= (state_nx == FINISH);
            period_cnt   <= cnt_nx;
        end
    end

endmodule
